// File: rtl/udp_loopback_buf.sv
// UDP loopback payload buffer: captures one received frame into RAM, then sequences its transmit.
// Optional build macro UDP_LOOPBACK_BUF_STATS_EN adds frame_cnt / drop_cnt statistics outputs.
module udp_loopback_buf #(
  parameter int ADDR_W     = 9,
  parameter int GAP_CYCLES = 16,
  parameter int TX_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rx_valid,
  input  logic [31:0]       rx_wr_data,
  input  logic [ADDR_W-1:0] rx_wr_addr,
  input  logic [15:0]       rx_data_length,
  input  logic              rx_done,
  input  logic [ADDR_W-1:0] ram_rd_addr,
  output logic [31:0]       ram_rd_data,
  output logic              tx_start,
  output logic [15:0]       tx_data_length,
  output logic [15:0]       tx_total_length,
  input  logic              tx_done,
  output logic [2:0]        buf_state
`ifdef UDP_LOOPBACK_BUF_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_READY = 3'd2,
    S_SEND  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int DEPTH       = 2 ** ADDR_W;
  localparam int MAX_PAYLOAD = 4 * DEPTH;
  localparam int CNT_MAX     = (TX_TIMEOUT > GAP_CYCLES) ? TX_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_mem [0:DEPTH-1];
  logic [15:0]       r_tx_data_length;
  logic [15:0]       r_tx_total_length;
  logic              w_capturing;
  logic              w_wr_en;
  logic              w_latch;
  logic              w_busy;
  logic [31:0]       w_raw_payload;
  logic [31:0]       w_payload;
  logic [15:0]       w_data_len;
  logic [15:0]       w_total_len;

  assign w_capturing = (r_state == S_IDLE) || (r_state == S_FILL);
  assign w_busy      = (r_state == S_READY) || (r_state == S_SEND) || (r_state == S_GAP);
  assign w_wr_en     = rx_valid && w_capturing;
  assign w_latch     = rx_done && w_capturing;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[rx_wr_addr] <= rx_wr_data;
    end
  end

  // Non-blocking read of the array gives old data on a same-address read/write collision.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ram_rd_data <= '0;
    end else begin
      ram_rd_data <= r_mem[ram_rd_addr];
    end
  end

  // Payload is the UDP length minus its 8-byte header, clamped to what the RAM can hold.
  always_comb begin
    w_raw_payload = '0;
    if (rx_data_length > 16'd8) begin
      w_raw_payload = 32'(rx_data_length) - 32'd8;
    end
    w_payload   = (w_raw_payload > 32'(MAX_PAYLOAD)) ? 32'(MAX_PAYLOAD) : w_raw_payload;
    w_data_len  = 16'(w_payload + 32'd8);
    w_total_len = 16'(w_payload + 32'd28);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_tx_data_length  <= 16'd8;
      r_tx_total_length <= 16'd28;
    end else if (w_latch) begin
      r_tx_data_length  <= w_data_len;
      r_tx_total_length <= w_total_len;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_done) begin
          w_next = S_READY;
        end else if (rx_valid) begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        if (rx_done) begin
          w_next = S_READY;
        end
      end
      S_READY: w_next = S_SEND;
      S_SEND: begin
        if (tx_done || (r_cnt == CNT_W'(TX_TIMEOUT - 1))) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start        = 1'b0;
    buf_state       = r_state;
    tx_data_length  = r_tx_data_length;
    tx_total_length = r_tx_total_length;
    if (r_state == S_READY) begin
      tx_start = 1'b1;
    end
  end

  // One counter serves both the SEND timeout and the GAP hold-off; it restarts on every state change.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == S_SEND) || (r_state == S_GAP)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

`ifdef UDP_LOOPBACK_BUF_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if ((r_state == S_READY) && (r_frame_cnt != 16'hFFFF)) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (rx_done && w_busy && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`else
  logic w_unused_busy;
  assign w_unused_busy = w_busy;
`endif

endmodule

// File: tb/tb_udp_loopback_buf.sv
// Self-checking bench for udp_loopback_buf against a behavioural frame/RAM/length model.
// Build with UDP_LOOPBACK_BUF_STATS_EN defined to also check the statistics counters.
module tb_udp_loopback_buf;

  localparam int ADDR_W  = 9;
  localparam int GAP     = 16;
  localparam int TIMEOUT = 100;
  localparam int MAXPAY  = 4 * (2 ** ADDR_W);

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              rxValid = 1'b0;
  logic [31:0]       rxWrData = '0;
  logic [ADDR_W-1:0] rxWrAddr = '0;
  logic [15:0]       rxDataLength = '0;
  logic              rxDone = 1'b0;
  logic [ADDR_W-1:0] ramRdAddr = '0;
  logic [31:0]       ramRdData;
  logic              txStart;
  logic [15:0]       txDataLength;
  logic [15:0]       txTotalLength;
  logic              txDone = 1'b0;
  logic [2:0]        bufState;
`ifdef UDP_LOOPBACK_BUF_STATS_EN
  logic [15:0]       frameCnt;
  logic [15:0]       dropCnt;
`endif

  int errors = 0;
  int checks = 0;
  int expFrames = 0;
  int expDrops = 0;
  logic [31:0] refMem [0:(2**ADDR_W)-1];

  udp_loopback_buf #(.ADDR_W(ADDR_W), .GAP_CYCLES(GAP), .TX_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .rx_valid(rxValid), .rx_wr_data(rxWrData), .rx_wr_addr(rxWrAddr),
    .rx_data_length(rxDataLength), .rx_done(rxDone), .ram_rd_addr(ramRdAddr),
    .ram_rd_data(ramRdData), .tx_start(txStart), .tx_data_length(txDataLength),
    .tx_total_length(txTotalLength), .tx_done(txDone), .buf_state(bufState)
`ifdef UDP_LOOPBACK_BUF_STATS_EN
    , .frame_cnt(frameCnt), .drop_cnt(dropCnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int expPayload(input int len);
    int p;
    p = len - 8;
    if (p < 0) p = 0;
    if (p > MAXPAY) p = MAXPAY;
    return p;
  endfunction

  function automatic logic [15:0] expDataLen(input int len);
    return 16'(expPayload(len) + 8);
  endfunction

  function automatic logic [15:0] expTotalLen(input int len);
    return 16'(expPayload(len) + 28);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input int a, input logic [31:0] d);
    rxValid = 1'b1;
    rxWrAddr = ADDR_W'(a);
    rxWrData = d;
    tick();
    rxValid = 1'b0;
  endtask

  task automatic pulseDone(input int len);
    rxDone = 1'b1;
    rxDataLength = 16'(len);
    tick();
    rxDone = 1'b0;
  endtask

  task automatic pulseTx();
    txDone = 1'b1;
    tick();
    txDone = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bufState !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", bufState); end
    checks++;
    if (txStart !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b want 0", txStart); end
    checks++;
    if (txDataLength !== 16'd8 || txTotalLength !== 16'd28) begin
      errors++; $display("[TB] FAIL reset_lengths: got %0d/%0d want 8/28", txDataLength, txTotalLength);
    end
    checks++;
    if (ramRdData !== 32'd0) begin errors++; $display("[TB] FAIL reset_rd_data: got %h want 0", ramRdData); end
`ifdef UDP_LOOPBACK_BUF_STATS_EN
    checks++;
    if (frameCnt !== 16'd0 || dropCnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_stats: got %0d/%0d want 0/0", frameCnt, dropCnt);
    end
`endif
    clr = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 32'h11111111 * (i + 1);
      writeWord(i, d);
      refMem[i] = d;
      if (i == 0) begin
        checks++;
        if (bufState !== 3'd1) begin errors++; $display("[TB] FAIL basic_fill: got %0d want 1", bufState); end
      end
    end
    pulseDone(24);
    expFrames++;
    checks++;
    if (bufState !== 3'd2 || txStart !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_ready: got state %0d start %b want 2/1", bufState, txStart);
    end
    checks++;
    if (txDataLength !== 16'd24 || txTotalLength !== 16'd44) begin
      errors++; $display("[TB] FAIL basic_lengths: got %0d/%0d want 24/44", txDataLength, txTotalLength);
    end
    tick();
    checks++;
    if (bufState !== 3'd3 || txStart !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_send: got state %0d start %b want 3/0", bufState, txStart);
    end
    for (int i = 0; i < 4; i++) begin
      ramRdAddr = ADDR_W'(i);
      tick();
      checks++;
      if (ramRdData !== refMem[i]) begin
        errors++; $display("[TB] FAIL basic_read%0d: got %h want %h", i, ramRdData, refMem[i]);
      end
    end
  endtask

  task automatic test_drop_in_send();
    rxValid = 1'b1;
    rxWrAddr = '0;
    rxWrData = 32'hDEADBEEF;
    rxDone = 1'b1;
    rxDataLength = 16'd100;
    tick();
    rxValid = 1'b0;
    rxDone = 1'b0;
    expDrops++;
    checks++;
    if (bufState !== 3'd3) begin errors++; $display("[TB] FAIL drop_state: got %0d want 3", bufState); end
    checks++;
    if (txDataLength !== 16'd24 || txTotalLength !== 16'd44) begin
      errors++; $display("[TB] FAIL drop_lengths: got %0d/%0d want 24/44", txDataLength, txTotalLength);
    end
    ramRdAddr = '0;
    tick();
    checks++;
    if (ramRdData !== refMem[0]) begin errors++; $display("[TB] FAIL drop_ram: got %h want %h", ramRdData, refMem[0]); end
`ifdef UDP_LOOPBACK_BUF_STATS_EN
    checks++;
    if (dropCnt !== 16'(expDrops) || frameCnt !== 16'(expFrames)) begin
      errors++; $display("[TB] FAIL drop_stats: got %0d/%0d want %0d/%0d", frameCnt, dropCnt, expFrames, expDrops);
    end
`endif
    pulseTx();
  endtask

  task automatic test_gap();
    logic [31:0] d;
    for (int g = 0; g < GAP; g++) begin
      checks++;
      if (bufState !== 3'd4) begin errors++; $display("[TB] FAIL gap_cycle%0d: got %0d want 4", g, bufState); end
      if (g == GAP - 1) begin
        writeWord(2, 32'hBAD0BAD0);
      end else begin
        tick();
      end
    end
    checks++;
    if (bufState !== 3'd0) begin errors++; $display("[TB] FAIL gap_end: got %0d want 0", bufState); end
    d = $urandom;
    ramRdAddr = ADDR_W'(2);
    writeWord(2, d);
    checks++;
    if (bufState !== 3'd1) begin errors++; $display("[TB] FAIL gap_accept: got %0d want 1", bufState); end
    checks++;
    if (ramRdData !== refMem[2]) begin errors++; $display("[TB] FAIL gap_old_data: got %h want %h", ramRdData, refMem[2]); end
    refMem[2] = d;
    tick();
    checks++;
    if (ramRdData !== refMem[2]) begin errors++; $display("[TB] FAIL gap_new_data: got %h want %h", ramRdData, refMem[2]); end
    pulseDone(16);
    expFrames++;
    tick();
    pulseTx();
    repeat (GAP) tick();
  endtask

  task automatic test_random_frames();
    int n;
    int a;
    int len;
    int addrs[$];
    logic [31:0] d;
    for (int f = 0; f < 4; f++) begin
      addrs.delete();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        a = $urandom_range(0, (2 ** ADDR_W) - 1);
        d = $urandom;
        writeWord(a, d);
        refMem[a] = d;
        addrs.push_back(a);
      end
      len = $urandom_range(0, 4000);
      pulseDone(len);
      expFrames++;
      checks++;
      if (txStart !== 1'b1 || txDataLength !== expDataLen(len) || txTotalLength !== expTotalLen(len)) begin
        errors++; $display("[TB] FAIL rand_len%0d: got %b %0d/%0d want 1 %0d/%0d (len %0d)", f, txStart,
                           txDataLength, txTotalLength, expDataLen(len), expTotalLen(len), len);
      end
      tick();
      for (int r = 0; r < 3; r++) begin
        a = addrs[$urandom_range(0, addrs.size() - 1)];
        ramRdAddr = ADDR_W'(a);
        tick();
        checks++;
        if (ramRdData !== refMem[a]) begin
          errors++; $display("[TB] FAIL rand_read%0d_%0d: got %h want %h (addr %0d)", f, r, ramRdData, refMem[a], a);
        end
      end
      pulseTx();
      repeat (GAP) tick();
      checks++;
      if (bufState !== 3'd0) begin errors++; $display("[TB] FAIL rand_idle%0d: got %0d want 0", f, bufState); end
    end
  endtask

  task automatic test_length_clamp();
    int lens[9] = '{5, 3000, 0, 7, 8, 9, 2056, 2057, 65535};
    foreach (lens[i]) begin
      pulseDone(lens[i]);
      expFrames++;
      checks++;
      if (txStart !== 1'b1 || txDataLength !== expDataLen(lens[i]) || txTotalLength !== expTotalLen(lens[i])) begin
        errors++; $display("[TB] FAIL clamp_len%0d: got %b %0d/%0d want 1 %0d/%0d", lens[i], txStart,
                           txDataLength, txTotalLength, expDataLen(lens[i]), expTotalLen(lens[i]));
      end
      tick();
      pulseTx();
      repeat (GAP) tick();
    end
`ifdef UDP_LOOPBACK_BUF_STATS_EN
    checks++;
    if (frameCnt !== 16'(expFrames)) begin errors++; $display("[TB] FAIL clamp_frames: got %0d want %0d", frameCnt, expFrames); end
`endif
  endtask

  task automatic test_timeout();
    pulseDone(40);
    expFrames++;
    tick();
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (bufState !== 3'd3) begin errors++; $display("[TB] FAIL timeout_last_send: got %0d want 3", bufState); end
    tick();
    checks++;
    if (bufState !== 3'd4) begin errors++; $display("[TB] FAIL timeout_exit: got %0d want 4", bufState); end
    repeat (GAP) tick();
    checks++;
    if (bufState !== 3'd0) begin errors++; $display("[TB] FAIL timeout_idle: got %0d want 0", bufState); end
  endtask

  task automatic test_reset_mid_send();
    logic [31:0] d;
    writeWord(7, 32'h0F0F0F0F);
    refMem[7] = 32'h0F0F0F0F;
    pulseDone(50);
    tick();
    tick();
    #2;
    clr = 1'b1;
    #1;
    expFrames = 0;
    expDrops = 0;
    checks++;
    if (bufState !== 3'd0 || txStart !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_state: got %0d/%b want 0/0", bufState, txStart);
    end
    checks++;
    if (txDataLength !== 16'd8 || txTotalLength !== 16'd28) begin
      errors++; $display("[TB] FAIL midreset_lengths: got %0d/%0d want 8/28", txDataLength, txTotalLength);
    end
    #2;
    clr = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      writeWord(i, d);
      refMem[i] = d;
    end
    pulseDone(20);
    expFrames++;
    checks++;
    if (bufState !== 3'd2 || txDataLength !== 16'd20 || txTotalLength !== 16'd40) begin
      errors++; $display("[TB] FAIL midreset_frame: got %0d %0d/%0d want 2 20/40", bufState, txDataLength, txTotalLength);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      ramRdAddr = ADDR_W'(i);
      tick();
      checks++;
      if (ramRdData !== refMem[i]) begin
        errors++; $display("[TB] FAIL midreset_read%0d: got %h want %h", i, ramRdData, refMem[i]);
      end
    end
    pulseTx();
    repeat (GAP) tick();
    checks++;
    if (bufState !== 3'd0) begin errors++; $display("[TB] FAIL midreset_idle: got %0d want 0", bufState); end
`ifdef UDP_LOOPBACK_BUF_STATS_EN
    checks++;
    if (frameCnt !== 16'(expFrames) || dropCnt !== 16'(expDrops)) begin
      errors++; $display("[TB] FAIL midreset_stats: got %0d/%0d want %0d/%0d", frameCnt, dropCnt, expFrames, expDrops);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_drop_in_send();
    test_gap();
    test_random_frames();
    test_length_clamp();
    test_timeout();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
